// File: rtl/serial_compare_ctrl_pkg.sv
// Shared types and helpers for the serial magnitude comparator controller.
// Holds the controller state encoding and the pair-counter width function.
package serial_compare_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // A single pair still needs one counter bit so the vector stays legal.
   function automatic int pair_cnt_width(input int width);
      return (width / 2 <= 1) ? 1 : $clog2(width / 2);
   endfunction

endpackage

// File: rtl/serial_compare_ctrl_compare_2bit.sv
// Combinational 2-bit unsigned magnitude compare slice.
// Exactly one of lt/eq/gt is high for any input pair.
module compare_2bit (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic       lt,
   output logic       eq,
   output logic       gt
);

   assign lt = (a < b);
   assign eq = (a == b);
   assign gt = (a > b);

endmodule

// File: rtl/serial_compare_ctrl.sv
// Multi-cycle WIDTH-bit magnitude comparator that steps one shared 2-bit
// slice MSB-first over shifted copies of the operands, exiting at the first unequal pair.
module serial_compare_ctrl
   import serial_compare_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   localparam int CW = pair_cnt_width(WIDTH);

   generate
      if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
         $error("serial_compare_ctrl: WIDTH must be even and at least 2");
      end
   endgenerate

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             lt_q, lt_d;
   logic             eq_q, eq_d;
   logic             gt_q, gt_d;
   logic             slice_lt, slice_eq, slice_gt;

   compare_2bit u_slice (
      .a  (a_sh_q[WIDTH-1 -: 2]),
      .b  (b_sh_q[WIDTH-1 -: 2]),
      .lt (slice_lt),
      .eq (slice_eq),
      .gt (slice_gt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         cnt_q   <= '0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         cnt_q   <= cnt_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      cnt_d   = cnt_q;
      lt_d    = lt_q;
      eq_d    = eq_q;
      gt_d    = gt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               cnt_d   = CW'(WIDTH / 2 - 1);
               lt_d    = 1'b0;
               eq_d    = 1'b0;
               gt_d    = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            // slice_eq is implied when neither lt nor gt fires.
            if (!slice_eq) begin
               lt_d    = slice_lt;
               gt_d    = slice_gt;
               eq_d    = 1'b0;
               state_d = DONE;
            end else if (cnt_q == '0) begin
               eq_d    = 1'b1;
               state_d = DONE;
            end else begin
               a_sh_d = a_sh_q << 2;
               b_sh_d = b_sh_q << 2;
               cnt_d  = cnt_q - CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign lt   = lt_q;
   assign eq   = eq_q;
   assign gt   = gt_q;

endmodule

// File: doc/serial_compare_ctrl.md
Name: serial_compare_ctrl

Overview:
- Multi-cycle magnitude comparator controller for two WIDTH-bit unsigned operands.
- Reuses a single 2-bit compare slice (compare_2bit), stepping MSB-first one bit-pair per clock.
- Exits early at the first unequal pair.
- Sits between a requesting datapath (start/done handshake) and the shared 2-bit comparator slice, trading latency for area.

Parameters:
- WIDTH, 8, operand width in bits; must be even and at least 2 (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepted start edge
- b  input  WIDTH  operand B; captured on the accepted start edge
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse; result valid
- lt  output  1  A < B; held after done
- eq  output  1  A == B; held after done
- gt  output  1  A > B; held after done

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, lt=eq=gt=0, shift registers and pair counter cleared.
- Reset mid-operation aborts the compare; no done pulse is generated.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at the edge: load a and b into shift registers, set pair counter to WIDTH/2-1, clear lt/eq/gt to 000, and go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - The slice sees the top 2 bits of each shift register (combinational).
  - If the slice reports lt or gt: register that result with eq=0, then go to DONE.
  - Else if the counter is 0 (last pair equal): register eq=1, then go to DONE.
  - Else: shift both registers left by 2, decrement the counter, and stay in RUN.
- DONE: done=1 for exactly this cycle; go to IDLE unconditionally.
- Latency: edge k after the accepted start ends RUN cycle k, where k is the 1-based index of the first unequal pair from the MSB. For equal operands, k=WIDTH/2.
  - done is high in the cycle following edge k.
  - Minimum: 2 cycles after the start cycle. Maximum: WIDTH/2+1.
- Start rules:
  - start in RUN or DONE is ignored. No queuing and no operand recapture.
  - Back-to-back: the earliest next acceptance is the IDLE cycle after DONE.
- Operands a and b may change freely after the accepted edge.
- Result encoding: lt/eq/gt is one-hot after any completed compare, and 000 only after reset or while a compare is in progress.
- Counter width is clog2(WIDTH/2), minimum 1 bit. The counter never wraps, because RUN exits at 0.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'b00, RUN=2'b01, DONE=2'b10. Encoding 2'b11 is unreachable and recovers to IDLE.
  - The pair-count width function.
- One sub-module: the existing compare_2bit slice, instantiated once on the shift-register MSB pairs.
- FSM, counter and shift registers stay in serial_compare_ctrl.

Test Plan:
1. WIDTH=8, a=8'hA5, b=8'hA5, start pulse -> busy for 5 cycles, done high 5 cycles after the start cycle, lt/eq/gt=010.
2. a=8'h40, b=8'h80 (MSB pair 01 vs 10) -> done 2 cycles after start, lt/eq/gt=100.
3. a=8'h13, b=8'h12 (only the last pair differs) -> done 5 cycles after start, lt/eq/gt=001.
4. Start a=8'h00, b=8'hFF; during RUN, pulse start with a=8'hFF, b=8'h00 -> second start ignored, result 100 with done at cycle 2; a new start in the following IDLE gives 001.
5. rst asserted during RUN of a=8'h11, b=8'h11 -> next cycle busy=0, done=0, lt/eq/gt=000, and no done pulse follows; a fresh start a=8'h22, b=8'h21 -> 001.
6. WIDTH=2 build, a=2'b11, b=2'b11 -> done 2 cycles after start, eq=1; start held high continuously -> a new compare is accepted every 3 cycles.
